// File: rtl/age_ordered_rs.sv
// age_ordered_rs
// Reservation station for the out-of-order core. Decoded ALU instructions wait
// here until both operands are available, snooping NUM_BCAST result-broadcast
// channels for the values they still need. Each cycle, the oldest ready entry
// is offered to the execution unit over a valid/ready handshake. Age is the
// ROB distance from the current ROB head.
//
// Ports:
//   clk_in, rst_n_in       clock, synchronous active-low reset
//   rdy_in                 global enable; 0 freezes every piece of state
//   flush                  mispredict flush; clears the station when rdy_in=1
//   rob_head               ROB head index, the reference point for age
//   dec_*                  decoder insert channel (dec_ready = room available)
//   bc_en/bc_rob_id/bc_data  packed result broadcasts, one slice per channel
//   iss_*                  issue channel carrying the selected entry's payload
//   count                  registered occupancy
module age_ordered_rs #(
  parameter int DEPTH      = 8,
  parameter int ROB_WIDTH  = 4,
  parameter int TYPE_WIDTH = 5,
  parameter int NUM_BCAST  = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           flush,
  input  logic [ROB_WIDTH-1:0]           rob_head,
  input  logic                           dec_valid,
  output logic                           dec_ready,
  input  logic [TYPE_WIDTH-1:0]          dec_type,
  input  logic [31:0]                    dec_data_j,
  input  logic [31:0]                    dec_data_k,
  input  logic                           dec_pending_j,
  input  logic                           dec_pending_k,
  input  logic [ROB_WIDTH-1:0]           dec_dep_j,
  input  logic [ROB_WIDTH-1:0]           dec_dep_k,
  input  logic [ROB_WIDTH-1:0]           dec_rob_id,
  input  logic [31:0]                    dec_imm,
  input  logic [NUM_BCAST-1:0]           bc_en,
  input  logic [NUM_BCAST*ROB_WIDTH-1:0] bc_rob_id,
  input  logic [NUM_BCAST*32-1:0]        bc_data,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [ROB_WIDTH-1:0]           iss_rob_id,
  output logic [TYPE_WIDTH-1:0]          iss_type,
  output logic [31:0]                    iss_data_j,
  output logic [31:0]                    iss_data_k,
  output logic [31:0]                    iss_imm,
  output logic [CNT_WIDTH-1:0]           count
);

  localparam int IDX_WIDTH = $clog2(DEPTH);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      pendJ_q, pendJ_d;
  logic [DEPTH-1:0]      pendK_q, pendK_d;
  logic [TYPE_WIDTH-1:0] type_q  [DEPTH];
  logic [TYPE_WIDTH-1:0] type_d  [DEPTH];
  logic [31:0]           dataJ_q [DEPTH];
  logic [31:0]           dataJ_d [DEPTH];
  logic [31:0]           dataK_q [DEPTH];
  logic [31:0]           dataK_d [DEPTH];
  logic [31:0]           imm_q   [DEPTH];
  logic [31:0]           imm_d   [DEPTH];
  logic [ROB_WIDTH-1:0]  depJ_q  [DEPTH];
  logic [ROB_WIDTH-1:0]  depJ_d  [DEPTH];
  logic [ROB_WIDTH-1:0]  depK_q  [DEPTH];
  logic [ROB_WIDTH-1:0]  depK_d  [DEPTH];
  logic [ROB_WIDTH-1:0]  robId_q [DEPTH];
  logic [ROB_WIDTH-1:0]  robId_d [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [DEPTH-1:0]      entryReady;
  logic                  selFound;
  logic [IDX_WIDTH-1:0]  selIdx;
  logic [IDX_WIDTH-1:0]  insIdx;
  logic [ROB_WIDTH-1:0]  bestAge;
  logic [ROB_WIDTH-1:0]  entryAge;
  logic                  insertFire;
  logic                  issueFire;
  logic [32:0]           hitJ, hitK;
  logic [32:0]           decHitJ, decHitK;

  // Returns {hit, data} for a producer tag. Channels are scanned from the top
  // down so that the lowest matching channel index is the last one written.
  function automatic logic [32:0] snoop(
    input logic [ROB_WIDTH-1:0]           dep,
    input logic [NUM_BCAST-1:0]           en,
    input logic [NUM_BCAST*ROB_WIDTH-1:0] ids,
    input logic [NUM_BCAST*32-1:0]        data
  );
    logic [32:0] res;
    res = '0;
    for (int c = NUM_BCAST - 1; c >= 0; c--) begin
      if (en[c] && (ids[c*ROB_WIDTH +: ROB_WIDTH] == dep)) begin
        res = {1'b1, data[c*32 +: 32]};
      end
    end
    return res;
  endfunction

  assign entryReady = valid_q & ~pendJ_q & ~pendK_q;

  // Oldest-ready selection. Age wraps naturally in ROB_WIDTH bits, so an
  // entry just past a wrapped head still counts as the oldest. ROB ids are
  // unique, so a strict less-than never has to break a tie.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    bestAge  = '0;
    entryAge = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryAge = robId_q[i] - rob_head;
      if (entryReady[i] && (!selFound || (entryAge < bestAge))) begin
        selFound = 1'b1;
        selIdx   = IDX_WIDTH'(i);
        bestAge  = entryAge;
      end
    end
  end

  // Lowest-index free slot; only consulted when count says there is room.
  always_comb begin
    insIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        insIdx = IDX_WIDTH'(i);
      end
    end
  end

  assign dec_ready  = (count_q < CNT_WIDTH'(DEPTH));
  assign insertFire = dec_valid && dec_ready && rdy_in;
  assign issueFire  = selFound && iss_ready && rdy_in;

  assign iss_valid  = selFound;
  assign iss_rob_id = robId_q[selIdx];
  assign iss_type   = type_q[selIdx];
  assign iss_data_j = dataJ_q[selIdx];
  assign iss_data_k = dataK_q[selIdx];
  assign iss_imm    = imm_q[selIdx];
  assign count      = count_q;

  // Next-state: wake-ups on resident entries, then retire the issued slot and
  // fill the insert slot. The two slots never coincide because one is valid
  // and the other is free.
  always_comb begin
    valid_d = valid_q;
    pendJ_d = pendJ_q;
    pendK_d = pendK_q;
    type_d  = type_q;
    dataJ_d = dataJ_q;
    dataK_d = dataK_q;
    imm_d   = imm_q;
    depJ_d  = depJ_q;
    depK_d  = depK_q;
    robId_d = robId_q;
    hitJ    = '0;
    hitK    = '0;
    decHitJ = snoop(dec_dep_j, bc_en, bc_rob_id, bc_data);
    decHitK = snoop(dec_dep_k, bc_en, bc_rob_id, bc_data);

    for (int i = 0; i < DEPTH; i++) begin
      hitJ = snoop(depJ_q[i], bc_en, bc_rob_id, bc_data);
      hitK = snoop(depK_q[i], bc_en, bc_rob_id, bc_data);
      if (valid_q[i] && pendJ_q[i] && hitJ[32]) begin
        dataJ_d[i] = hitJ[31:0];
        pendJ_d[i] = 1'b0;
      end
      if (valid_q[i] && pendK_q[i] && hitK[32]) begin
        dataK_d[i] = hitK[31:0];
        pendK_d[i] = 1'b0;
      end
    end

    if (issueFire) begin
      valid_d[selIdx] = 1'b0;
    end

    if (insertFire) begin
      valid_d[insIdx] = 1'b1;
      type_d[insIdx]  = dec_type;
      imm_d[insIdx]   = dec_imm;
      robId_d[insIdx] = dec_rob_id;
      depJ_d[insIdx]  = dec_dep_j;
      depK_d[insIdx]  = dec_dep_k;
      dataJ_d[insIdx] = dec_data_j;
      pendJ_d[insIdx] = dec_pending_j;
      dataK_d[insIdx] = dec_data_k;
      pendK_d[insIdx] = dec_pending_k;
      if (dec_pending_j && decHitJ[32]) begin
        dataJ_d[insIdx] = decHitJ[31:0];
        pendJ_d[insIdx] = 1'b0;
      end
      if (dec_pending_k && decHitK[32]) begin
        dataK_d[insIdx] = decHitK[31:0];
        pendK_d[insIdx] = 1'b0;
      end
    end

    count_d = count_q + CNT_WIDTH'(insertFire) - CNT_WIDTH'(issueFire);
  end

  // State register. Reset works regardless of rdy_in; a flush only takes
  // effect while enabled and wins over any insert or issue in that cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || (rdy_in && flush)) begin
      valid_q <= '0;
      pendJ_q <= '0;
      pendK_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i]  <= '0;
        dataJ_q[i] <= '0;
        dataK_q[i] <= '0;
        imm_q[i]   <= '0;
        depJ_q[i]  <= '0;
        depK_q[i]  <= '0;
        robId_q[i] <= '0;
      end
    end else if (rdy_in) begin
      valid_q <= valid_d;
      pendJ_q <= pendJ_d;
      pendK_q <= pendK_d;
      count_q <= count_d;
      type_q  <= type_d;
      dataJ_q <= dataJ_d;
      dataK_q <= dataK_d;
      imm_q   <= imm_d;
      depJ_q  <= depJ_d;
      depK_q  <= depK_d;
      robId_q <= robId_d;
    end
  end

endmodule
